gpio_trigger_conditioner: RTL and testbench

- Upstream stage of the GPIO trigger-pulse generator: turns a raw, asynchronous GPIO level into a clean single-cycle trigger pulse for that generator's trig_i.
- Pipeline: 2-FF synchroniser, glitch filter, edge select, arm/single-shot control and retrigger holdoff.
- Also accepts a software trigger from the register bank, so delayed-pulse experiments can be fired without external hardware.

---
 rtl/gpio_trigger_conditioner_pkg.sv | 31 +++
 rtl/gpio_trigger_conditioner_if.sv | 31 +++
 rtl/gpio_trigger_conditioner_filter.sv | 51 +++++
 rtl/gpio_trigger_conditioner.sv | 133 +++++++++++++
 tb/tb_gpio_trigger_conditioner.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpio_trigger_conditioner_pkg.sv
// Shared types for the GPIO trigger conditioner: edge-select codes, FSM
// states and the edge-qualification helper used by the top level.
package gpio_trig_pkg;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_BOTH = 2'b10,
    EDGE_NONE = 2'b11
  } edge_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ARMED   = 2'b01,
    ST_HOLDOFF = 2'b10
  } state_e;

  // True when the transition prev -> cur matches the selected edge type.
  function automatic logic edge_hit(input logic [1:0] sel, input logic cur, input logic prev);
    logic hit;
    hit = 1'b0;
    case (edge_sel_e'(sel))
      EDGE_RISE: hit = cur & ~prev;
      EDGE_FALL: hit = ~cur & prev;
      EDGE_BOTH: hit = cur ^ prev;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/gpio_trigger_conditioner_if.sv
// Register-bank side of the GPIO trigger conditioner: configuration,
// software trigger and status. master = register bank, slave = conditioner.
interface gpio_trig_ctrl_if #(
  parameter int FILTER_WIDTH  = 8,
  parameter int HOLDOFF_WIDTH = 26,
  parameter int COUNT_WIDTH   = 32
);
  logic                     sw_trig_i;
  logic                     enable_i;
  logic                     single_shot_i;
  logic                     arm_i;
  logic [1:0]               edge_sel_i;
  logic [FILTER_WIDTH-1:0]  filter_cycles_i;
  logic [HOLDOFF_WIDTH-1:0] holdoff_cycles_i;
  logic                     clear_count_i;
  logic                     armed_o;
  logic                     level_o;
  logic [COUNT_WIDTH-1:0]   trig_count_o;

  modport master (
    output sw_trig_i, enable_i, single_shot_i, arm_i, edge_sel_i,
           filter_cycles_i, holdoff_cycles_i, clear_count_i,
    input  armed_o, level_o, trig_count_o
  );

  modport slave (
    input  sw_trig_i, enable_i, single_shot_i, arm_i, edge_sel_i,
           filter_cycles_i, holdoff_cycles_i, clear_count_i,
    output armed_o, level_o, trig_count_o
  );
endinterface

// File: rtl/gpio_trigger_conditioner_filter.sv
// Two-flop synchroniser followed by a stability-counter glitch filter.
// The filtered level only follows the synchronised input once it has
// differed from it for filter_cycles_i + 1 consecutive samples.
module gpio_glitch_filter #(
  parameter int FILTER_WIDTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    gpio_i,
  input  logic [FILTER_WIDTH-1:0] filter_cycles_i,
  output logic                    filt_o
);

  logic                    s1_q, s2_q;
  logic                    filt_q, filt_d;
  logic [FILTER_WIDTH-1:0] cnt_q, cnt_d;

  // Stability counter: >= lets a lowered threshold take effect at once.
  always_comb begin
    // NOTE: defaults first, so no path leaves a variable unassigned and infers a latch.
    filt_d = filt_q;
    cnt_d  = '0;
    if (s2_q != filt_q) begin
      if (cnt_q >= filter_cycles_i) begin
        filt_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchroniser and filter state; reset discards any partial count.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking so every flop samples pre-edge values (s2_q sees the old s1_q).
    if (rst_i) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= gpio_i;
      s2_q   <= s1_q;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  // Filtered level out
  always_comb filt_o = filt_q;

endmodule

// File: rtl/gpio_trigger_conditioner.sv
// GPIO trigger conditioner: synchronise + filter the raw GPIO level,
// qualify edges, merge the software trigger, and gate the result through
// an IDLE/ARMED/HOLDOFF controller into a single-cycle trig_o.
// Optional macro GPIO_TRIG_COUNT_EN adds a saturating trigger counter;
// without it trig_count_o is tied to 0 and clear_count_i is ignored.
module gpio_trigger_conditioner
  import gpio_trig_pkg::*;
#(
  parameter int FILTER_WIDTH  = 8,
  parameter int HOLDOFF_WIDTH = 26,
  parameter int COUNT_WIDTH   = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             gpio_i,
  output logic             trig_o,
  gpio_trig_ctrl_if.slave  ctrl
);

  logic                     filt;
  logic                     filt_prev_q;
  logic                     evt;
  logic                     fire;
  state_e                   state_q, state_d;
  logic [HOLDOFF_WIDTH-1:0] hold_q, hold_d;
  logic                     trig_q, trig_d;

  gpio_glitch_filter #(
    .FILTER_WIDTH (FILTER_WIDTH)
  ) u_filter (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .gpio_i          (gpio_i),
    .filter_cycles_i (ctrl.filter_cycles_i),
    .filt_o          (filt)
  );

  // Previous filtered level for edge detection
  always_ff @(posedge clk_i) begin
    if (rst_i) filt_prev_q <= 1'b0;
    else       filt_prev_q <= filt;
  end

  // Event qualification; the trig_q term stops back-to-back pulses when H = 0
  always_comb begin
    evt  = edge_hit(ctrl.edge_sel_i, filt, filt_prev_q) | ctrl.sw_trig_i;
    fire = (state_q == ST_ARMED) && ctrl.enable_i && evt && !trig_q;
  end

  // FSM state register, holdoff counter and trigger flop
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      trig_q  <= trig_d;
    end
  end

  // FSM next state; holdoff length is captured at trigger time
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    trig_d  = 1'b0;
    if (!ctrl.enable_i) begin
      state_d = ST_IDLE;
      hold_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // An event coinciding with arm_i is dropped: only ARMED can fire.
          if (!ctrl.single_shot_i || ctrl.arm_i) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (fire) begin
            trig_d = 1'b1;
            if (ctrl.holdoff_cycles_i != '0) begin
              state_d = ST_HOLDOFF;
              hold_d  = ctrl.holdoff_cycles_i;
            end else if (ctrl.single_shot_i) begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_HOLDOFF: begin
          hold_d = hold_q - 1'b1;
          if (hold_q <= 1) begin
            hold_d  = '0;
            state_d = ctrl.single_shot_i ? ST_IDLE : ST_ARMED;
          end
        end
        default: begin
          state_d = ST_IDLE;
          hold_d  = '0;
        end
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    trig_o       = trig_q;
    ctrl.armed_o = (state_q == ST_ARMED);
    ctrl.level_o = filt;
  end

`ifdef GPIO_TRIG_COUNT_EN
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  // Saturating trigger counter; clear wins over a simultaneous increment
  always_comb begin
    count_d = count_q;
    if (ctrl.clear_count_i)             count_d = '0;
    else if (trig_d && !(&count_q))     count_d = count_q + 1'b1;
  end

  // Counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  assign ctrl.trig_count_o = count_q;
`else
  logic unused_clear;
  assign unused_clear      = ctrl.clear_count_i;
  assign ctrl.trig_count_o = '0;
`endif

endmodule

// File: tb/tb_gpio_trigger_conditioner.sv
// Self-checking bench for gpio_trigger_conditioner: directed scenarios
// followed by randomized traffic, all compared cycle by cycle against a
// behavioural model built from the block's timing and arming rules.
module tb_gpio_trigger_conditioner;

  localparam int FW = 8;
  localparam int HW = 26;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic rst;
  logic gpio;
  logic trig;

  gpio_trig_ctrl_if #(.FILTER_WIDTH(FW), .HOLDOFF_WIDTH(HW), .COUNT_WIDTH(CW)) ctrl ();

  gpio_trigger_conditioner #(
    .FILTER_WIDTH (FW),
    .HOLDOFF_WIDTH(HW),
    .COUNT_WIDTH  (CW)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .gpio_i (gpio),
    .trig_o (trig),
    .ctrl   (ctrl)
  );

`ifdef GPIO_TRIG_COUNT_EN
  // Narrow-counter copy sharing all inputs, for the saturation check.
  logic trig4;
  gpio_trig_ctrl_if #(.FILTER_WIDTH(FW), .HOLDOFF_WIDTH(HW), .COUNT_WIDTH(4)) ctrl4 ();
  assign ctrl4.sw_trig_i        = ctrl.sw_trig_i;
  assign ctrl4.enable_i         = ctrl.enable_i;
  assign ctrl4.single_shot_i    = ctrl.single_shot_i;
  assign ctrl4.arm_i            = ctrl.arm_i;
  assign ctrl4.edge_sel_i       = ctrl.edge_sel_i;
  assign ctrl4.filter_cycles_i  = ctrl.filter_cycles_i;
  assign ctrl4.holdoff_cycles_i = ctrl.holdoff_cycles_i;
  assign ctrl4.clear_count_i    = ctrl.clear_count_i;

  gpio_trigger_conditioner #(
    .FILTER_WIDTH (FW),
    .HOLDOFF_WIDTH(HW),
    .COUNT_WIDTH  (4)
  ) dut4 (
    .clk_i  (clk),
    .rst_i  (rst),
    .gpio_i (gpio),
    .trig_o (trig4),
    .ctrl   (ctrl4)
  );
`endif

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int n_seen   = 0;

  // Behavioural model state
  bit          dly[$];     // gpio samples still inside the two-stage synchroniser
  bit          last_v;     // latest synchronised sample
  int          run_len;    // consecutive synchronised samples equal to last_v
  bit          m_level, m_prev, m_armed, m_trig;
  int          m_hold;     // remaining dead-time cycles, 0 when not in holdoff
  logic [31:0] m_count;
  logic [3:0]  m_count4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    dly      = '{1'b0, 1'b0};
    last_v   = 1'b0;
    run_len  = 0;
    m_level  = 1'b0;
    m_prev   = 1'b0;
    m_armed  = 1'b0;
    m_trig   = 1'b0;
    m_hold   = 0;
    m_count  = '0;
    m_count4 = '0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    bit v, evt, fire, new_level;
    int d;
    if (rst) begin
      model_reset();
      return;
    end
    v = dly.pop_front();
    dly.push_back(gpio);
    run_len = (v == last_v) ? run_len + 1 : 1;
    last_v  = v;
    // A new level is accepted once it has persisted for F+1 samples.
    new_level = (v != m_level && run_len > int'(ctrl.filter_cycles_i)) ? v : m_level;
    d   = int'(m_level) - int'(m_prev);
    evt = ctrl.sw_trig_i
       || (ctrl.edge_sel_i == 2'd0 && d == 1)
       || (ctrl.edge_sel_i == 2'd1 && d == -1)
       || (ctrl.edge_sel_i == 2'd2 && d != 0);
    fire = 1'b0;
    if (!ctrl.enable_i) begin
      m_armed = 1'b0;
      m_hold  = 0;
    end else if (m_hold > 0) begin
      m_hold--;
      if (m_hold == 0) m_armed = !ctrl.single_shot_i;
    end else if (m_armed) begin
      fire = evt && !m_trig;
      if (fire) begin
        if (ctrl.holdoff_cycles_i != 0) begin
          m_hold  = int'(ctrl.holdoff_cycles_i);
          m_armed = 1'b0;
        end else begin
          m_armed = !ctrl.single_shot_i;
        end
      end
    end else begin
      m_armed = !ctrl.single_shot_i || ctrl.arm_i;
    end
    m_trig = fire;
    if (ctrl.clear_count_i) begin
      m_count  = '0;
      m_count4 = '0;
    end else if (fire) begin
      if (m_count != 32'hFFFF_FFFF) m_count++;
      if (m_count4 != 4'hF) m_count4++;
    end
    m_prev  = m_level;
    m_level = new_level;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (trig === 1'b1) n_seen++;
    chk("trig_o", 32'(trig), 32'(m_trig));
    chk("armed_o", 32'(ctrl.armed_o), 32'(m_armed));
    chk("level_o", 32'(ctrl.level_o), 32'(m_level));
`ifdef GPIO_TRIG_COUNT_EN
    chk("trig_count_o", ctrl.trig_count_o, m_count);
    chk("trig_count4_o", 32'(ctrl4.trig_count_o), 32'(m_count4));
`else
    chk("trig_count_o", ctrl.trig_count_o, 32'd0);
`endif
  endtask

  task automatic pulse_sw();
    ctrl.sw_trig_i = 1'b1;
    tick();
    ctrl.sw_trig_i = 1'b0;
  endtask

  initial begin
    int base;
    int first_idx;

    rst                   = 1'b1;
    gpio                  = 1'b0;
    ctrl.sw_trig_i        = 1'b0;
    ctrl.enable_i         = 1'b0;
    ctrl.single_shot_i    = 1'b0;
    ctrl.arm_i            = 1'b0;
    ctrl.edge_sel_i       = 2'd0;
    ctrl.filter_cycles_i  = '0;
    ctrl.holdoff_cycles_i = '0;
    ctrl.clear_count_i    = 1'b0;
    model_reset();

    // Reset state
    repeat (3) tick();
    chk("rst_trig", 32'(trig), 32'd0);
    chk("rst_armed", 32'(ctrl.armed_o), 32'd0);
    chk("rst_level", 32'(ctrl.level_o), 32'd0);
    chk("rst_count", ctrl.trig_count_o, 32'd0);

    // Continuous, rising, F=0, H=0: trigger 3 edges after first sample
    rst = 1'b0;
    ctrl.enable_i = 1'b1;
    repeat (4) tick();
    chk("t1_armed", 32'(ctrl.armed_o), 32'd1);
    gpio = 1'b1;
    repeat (3) tick();
    chk("t1_early", 32'(trig), 32'd0);
    tick();
    chk("t1_latency", 32'(trig), 32'd1);
    tick();
    chk("t1_single", 32'(trig), 32'd0);
`ifdef GPIO_TRIG_COUNT_EN
    chk("t1_count", ctrl.trig_count_o, 32'd1);
`endif

    // Glitch filter F=5: 3-cycle pulse rejected, 8-cycle pulse passes
    ctrl.filter_cycles_i = 8'd5;
    gpio = 1'b0;
    repeat (12) tick();
    base = n_seen;
    gpio = 1'b1;
    repeat (3) tick();
    gpio = 1'b0;
    repeat (12) tick();
    chk("glitch_trig", 32'(n_seen - base), 32'd0);
    chk("glitch_level", 32'(ctrl.level_o), 32'd0);
    first_idx = -1;
    for (int i = 0; i < 16; i++) begin
      gpio = (i < 8);
      tick();
      if (trig === 1'b1 && first_idx < 0) first_idx = i;
    end
    chk("f8_latency", 32'(first_idx), 32'd8);
    gpio = 1'b0;
    repeat (10) tick();

    // Holdoff H=100, rises every 40 cycles: 1st and 4th trigger
    ctrl.filter_cycles_i  = '0;
    ctrl.holdoff_cycles_i = 26'd100;
    base = n_seen;
    for (int i = 0; i < 170; i++) begin
      gpio = ((i % 40) < 20);
      tick();
    end
    chk("hold_trigs", 32'(n_seen - base), 32'd2);
    gpio = 1'b0;
    ctrl.holdoff_cycles_i = '0;
    repeat (110) tick();

    // Single-shot: arm, two edges -> one trigger and disarm
    ctrl.single_shot_i = 1'b1;
    ctrl.enable_i = 1'b0;
    tick();
    ctrl.enable_i = 1'b1;
    repeat (3) tick();
    chk("ss_idle", 32'(ctrl.armed_o), 32'd0);
    ctrl.arm_i = 1'b1;
    tick();
    ctrl.arm_i = 1'b0;
    chk("ss_armed", 32'(ctrl.armed_o), 32'd1);
    base = n_seen;
    for (int i = 0; i < 30; i++) begin
      gpio = ((i % 15) < 5);
      tick();
    end
    chk("ss_one_trig", 32'(n_seen - base), 32'd1);
    chk("ss_disarmed", 32'(ctrl.armed_o), 32'd0);
    // Re-arm, then software trigger
    ctrl.arm_i = 1'b1;
    tick();
    ctrl.arm_i = 1'b0;
    pulse_sw();
    chk("ss_sw_trig", 32'(trig), 32'd1);
    tick();
    chk("ss_sw_disarm", 32'(ctrl.armed_o), 32'd0);
    // Software trigger in IDLE does nothing
    base = n_seen;
    pulse_sw();
    repeat (3) tick();
    chk("idle_sw", 32'(n_seen - base), 32'd0);
    // Arm together with an event: arms, event dropped
    ctrl.arm_i = 1'b1;
    ctrl.sw_trig_i = 1'b1;
    tick();
    ctrl.arm_i = 1'b0;
    ctrl.sw_trig_i = 1'b0;
    chk("arm_evt_trig", 32'(trig), 32'd0);
    chk("arm_evt_armed", 32'(ctrl.armed_o), 32'd1);
    tick();
    chk("arm_evt_dropped", 32'(trig), 32'd0);
    pulse_sw();
    tick();

    // GPIO edge and software trigger in the same cycle: one pulse
    ctrl.single_shot_i = 1'b0;
    repeat (2) tick();
    base = n_seen;
    gpio = 1'b1;
    repeat (3) tick();
    pulse_sw();
    repeat (3) tick();
    chk("dual_one_trig", 32'(n_seen - base), 32'd1);
    gpio = 1'b0;
    repeat (4) tick();

    // Enable dropped mid-holdoff, re-raised: ARMED next cycle, edge fires
    ctrl.holdoff_cycles_i = 26'd50;
    pulse_sw();
    repeat (10) tick();
    chk("hold_mid", 32'(ctrl.armed_o), 32'd0);
    ctrl.enable_i = 1'b0;
    repeat (3) tick();
    ctrl.enable_i = 1'b1;
    tick();
    chk("reen_armed", 32'(ctrl.armed_o), 32'd1);
    gpio = 1'b1;
    repeat (4) tick();
    chk("reen_trig", 32'(trig), 32'd1);
    gpio = 1'b0;
    ctrl.holdoff_cycles_i = '0;
    repeat (55) tick();

    // Reset mid-filter discards progress
    ctrl.filter_cycles_i = 8'd20;
    gpio = 1'b1;
    base = n_seen;
    repeat (12) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    gpio = 1'b0;
    repeat (10) tick();
    chk("rstf_level", 32'(ctrl.level_o), 32'd0);
    chk("rstf_trig", 32'(n_seen - base), 32'd0);
    ctrl.filter_cycles_i = '0;

`ifdef GPIO_TRIG_COUNT_EN
    // Clear coincident with a trigger wins; 4-bit counter saturates at 15
    ctrl.clear_count_i = 1'b1;
    pulse_sw();
    ctrl.clear_count_i = 1'b0;
    chk("clr_trig", 32'(trig), 32'd1);
    chk("clr_count", ctrl.trig_count_o, 32'd0);
    for (int i = 0; i < 17; i++) begin
      pulse_sw();
      tick();
    end
    chk("sat4_count", 32'(ctrl4.trig_count_o), 32'd15);
    chk("sat32_count", ctrl.trig_count_o, 32'd17);
`endif

    // Randomized traffic checked against the model every cycle
    for (int blk = 0; blk < 8; blk++) begin
      ctrl.edge_sel_i       = 2'($urandom_range(0, 3));
      ctrl.single_shot_i    = 1'($urandom_range(0, 1));
      ctrl.filter_cycles_i  = 8'($urandom_range(0, 6));
      ctrl.holdoff_cycles_i = 26'($urandom_range(0, 12));
      for (int i = 0; i < 100; i++) begin
        if ($urandom_range(0, 5) == 0) gpio = ~gpio;
        ctrl.sw_trig_i     = ($urandom_range(0, 19) == 0);
        ctrl.arm_i         = ($urandom_range(0, 9) == 0);
        ctrl.enable_i      = ($urandom_range(0, 39) != 0);
        ctrl.clear_count_i = ($urandom_range(0, 49) == 0);
        rst                = ($urandom_range(0, 299) == 0);
        if ($urandom_range(0, 49) == 0) ctrl.filter_cycles_i = 8'($urandom_range(0, 6));
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
